// File: rtl/reg_bank_write_arbiter.sv
// -----------------------------------------------------------------------------
// reg_bank_write_arbiter
//
// Shares a single write path into a bank of enable-loaded holding registers
// among N_REQ requesters. A rotating-priority arbiter picks one requester per
// transaction. The transaction runs IDLE -> LOAD -> ACK:
//   - LOAD drives a one-hot load enable and the captured data to the bank.
//   - ACK pulses the served requester's acknowledge for one cycle.
// Every output is registered, so there is no combinational path from req.
//
// Ports
//   clk      in   1              system clock, rising edge
//   reset    in   1              synchronous, active-high reset
//   req      in   N_REQ          level write request per requester, held until ack
//   wr_addr  in   N_REQ*ADDR_W   flattened target register index, slice i = requester i
//   wr_data  in   N_REQ*DATA_W   flattened write data, slice i = requester i
//   ack      out  N_REQ          one-hot single-cycle acknowledge to the served requester
//   reg_en   out  2**ADDR_W      one-hot load enable to the register bank
//   reg_dd   out  DATA_W         common data to the register bank
//   busy     out  1              high while a transaction is in LOAD or ACK
// -----------------------------------------------------------------------------
module reg_bank_write_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 5,
  parameter int ADDR_W = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   wr_addr,
  input  logic [N_REQ*DATA_W-1:0]   wr_data,
  output logic [N_REQ-1:0]          ack,
  output logic [(2**ADDR_W)-1:0]    reg_en,
  output logic [DATA_W-1:0]         reg_dd,
  output logic                      busy
);

  localparam int N_REG = 2 ** ADDR_W;
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [IDX_W-1:0]   r_ptr;      // requester with highest priority next time
  logic [IDX_W-1:0]   r_winner;   // requester being served by the current transaction

  // The output registers double as the transaction latches: r_reg_en holds the
  // decoded captured address and r_reg_dd holds the captured data, so the bank
  // only ever sees values frozen at grant time, never the live inputs.
  logic [N_REQ-1:0]   r_ack;
  logic [N_REG-1:0]   r_reg_en;
  logic [DATA_W-1:0]  r_reg_dd;
  logic               r_busy;

  logic               w_found;
  logic [IDX_W-1:0]   w_winner;
  int                 w_scan;
  logic [ADDR_W-1:0]  w_win_addr;
  logic [DATA_W-1:0]  w_win_data;
  logic [N_REG-1:0]   w_en_dec;
  logic [N_REQ-1:0]   w_ack_dec;
  logic [IDX_W-1:0]   w_ptr_nxt;

  // ---------------------------------------------------------------------------
  // Rotating-priority search: first set req bit at or above r_ptr, wrapping.
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven from always_comb gets a default before any
  // conditional assignment; otherwise a path that skips it infers a latch.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_scan   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      w_scan = int'(r_ptr) + i;
      if (w_scan >= N_REQ) begin
        w_scan = w_scan - N_REQ;
      end
      if (!w_found && req[w_scan]) begin
        w_found  = 1'b1;
        w_winner = IDX_W'(w_scan);
      end
    end
  end

  assign w_win_addr = wr_addr[int'(w_winner)*ADDR_W +: ADDR_W];
  assign w_win_data = wr_data[int'(w_winner)*DATA_W +: DATA_W];

  always_comb begin
    w_en_dec             = '0;
    w_en_dec[w_win_addr] = 1'b1;
  end

  always_comb begin
    w_ack_dec           = '0;
    w_ack_dec[r_winner] = 1'b1;
  end

  // Explicit wrap keeps the pointer legal when N_REQ is not a power of two.
  assign w_ptr_nxt = (r_winner == IDX_W'(N_REQ - 1)) ? '0 : r_winner + 1'b1;

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_ACK;
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of the order the blocks are evaluated.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs, winner and pointer.
  // Outputs are loaded on the edge that enters each state, so reg_en is high
  // throughout LOAD and ack throughout ACK. A reset in LOAD or ACK clears
  // everything, so an aborted transaction never produces an ack.
  // ---------------------------------------------------------------------------
  // NOTE: reg_dd is reset even though the bank ignores it while reg_en is low,
  // so the outputs come out of reset in a known all-zero state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr    <= '0;
      r_winner <= '0;
      r_ack    <= '0;
      r_reg_en <= '0;
      r_reg_dd <= '0;
      r_busy   <= 1'b0;
    end else begin
      // ack and reg_en are single-cycle pulses by default.
      r_ack    <= '0;
      r_reg_en <= '0;
      r_busy   <= (w_state_nxt != S_IDLE);
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_winner <= w_winner;
            r_reg_en <= w_en_dec;
            r_reg_dd <= w_win_data;
          end
        end
        S_LOAD: begin
          r_ack <= w_ack_dec;
        end
        S_ACK: begin
          r_ptr <= w_ptr_nxt;
        end
        default: begin
          r_ack <= '0;
        end
      endcase
    end
  end

  assign ack    = r_ack;
  assign reg_en = r_reg_en;
  assign reg_dd = r_reg_dd;
  assign busy   = r_busy;

endmodule
